// File: rtl/ecc_secded_decoder.sv
// Two-stage SECDED (extended Hamming) decoder with valid/ready handshakes on both sides.
// Optional error counters are compiled in when ECC_DEC_ERR_CNT_EN is defined.
module ecc_secded_decoder #(
    parameter int DATA_W = 32,
    // Smallest P with 2**P >= DATA_W+P+1, unrolled for the supported width range
    localparam int P    = (DATA_W <= 4)  ? 3 :
                          (DATA_W <= 11) ? 4 :
                          (DATA_W <= 26) ? 5 :
                          (DATA_W <= 57) ? 6 :
                          (DATA_W <= 120) ? 7 : 8,
    localparam int N    = DATA_W + P,
    localparam int CW_W = N + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CW_W-1:0]   cw_i,
    input  logic              valid_i,
    output logic              ready_o,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              err_corr_o,
    output logic              err_uncorr_o,
    output logic [P-1:0]      syndrome_o
`ifdef ECC_DEC_ERR_CNT_EN
    ,
    input  logic              cnt_clr_i,
    output logic [15:0]       corr_cnt_o,
    output logic [15:0]       uncorr_cnt_o
`endif
);

    localparam logic [P-1:0] N_LAST = P'(N);

    logic              s1_valid_q;
    logic [CW_W-1:0]   s1_cw_q;
    logic [P-1:0]      s1_syn_q;
    logic [P-1:0]      s1_syn_d;
    logic              s1_par_q;
    logic              s1_par_d;

    logic              s2_valid_q;
    logic [DATA_W-1:0] s2_data_q;
    logic [DATA_W-1:0] s2_data_d;
    logic              s2_corr_q;
    logic              s2_corr_d;
    logic              s2_uncorr_q;
    logic              s2_uncorr_d;
    logic [P-1:0]      s2_syn_q;

    logic              s1_adv;
    logic              s2_take;
    logic [CW_W-1:0]   cw_fix;

    assign s2_take = ~s2_valid_q | ready_i;
    assign s1_adv  = s1_valid_q & s2_take;
    assign ready_o = ~s1_valid_q | s1_adv;

    always_comb begin
        s1_syn_d = '0;
        for (int unsigned pos = 1; pos < CW_W; pos++) begin
            if (cw_i[pos]) s1_syn_d ^= P'(pos);
        end
        s1_par_d = ^cw_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_cw_q    <= '0;
            s1_syn_q   <= '0;
            s1_par_q   <= 1'b0;
        end else if (ready_o) begin
            s1_valid_q <= valid_i;
            if (valid_i) begin
                s1_cw_q  <= cw_i;
                s1_syn_q <= s1_syn_d;
                s1_par_q <= s1_par_d;
            end
        end
    end

    // Q=1 means an odd number of flips: correctable unless S points past the codeword.
    always_comb begin
        int unsigned j;
        cw_fix      = s1_cw_q;
        s2_corr_d   = 1'b0;
        s2_uncorr_d = 1'b0;
        if (s1_par_q) begin
            if (s1_syn_q == '0) begin
                s2_corr_d = 1'b1;
            end else if (s1_syn_q <= N_LAST) begin
                s2_corr_d = 1'b1;
                cw_fix[s1_syn_q] = ~s1_cw_q[s1_syn_q];
            end else begin
                s2_uncorr_d = 1'b1;
            end
        end else if (s1_syn_q != '0) begin
            s2_uncorr_d = 1'b1;
        end

        j         = 0;
        s2_data_d = '0;
        for (int unsigned pos = 1; pos < CW_W; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                s2_data_d[j] = cw_fix[pos];
                j++;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q  <= 1'b0;
            s2_data_q   <= '0;
            s2_corr_q   <= 1'b0;
            s2_uncorr_q <= 1'b0;
            s2_syn_q    <= '0;
        end else if (s2_take) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_data_q   <= s2_data_d;
                s2_corr_q   <= s2_corr_d;
                s2_uncorr_q <= s2_uncorr_d;
                s2_syn_q    <= s1_syn_q;
            end
        end
    end

    assign valid_o      = s2_valid_q;
    assign data_o       = s2_data_q;
    assign err_corr_o   = s2_corr_q;
    assign err_uncorr_o = s2_uncorr_q;
    assign syndrome_o   = s2_syn_q;

`ifdef ECC_DEC_ERR_CNT_EN
    logic [15:0] corr_cnt_q;
    logic [15:0] uncorr_cnt_q;
    logic        beat;

    assign beat = s2_valid_q & ready_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            corr_cnt_q   <= '0;
            uncorr_cnt_q <= '0;
        end else if (cnt_clr_i) begin
            corr_cnt_q   <= '0;
            uncorr_cnt_q <= '0;
        end else begin
            if (beat && s2_corr_q && (corr_cnt_q != '1))
                corr_cnt_q <= corr_cnt_q + 16'd1;
            if (beat && s2_uncorr_q && (uncorr_cnt_q != '1))
                uncorr_cnt_q <= uncorr_cnt_q + 16'd1;
        end
    end

    assign corr_cnt_o   = corr_cnt_q;
    assign uncorr_cnt_o = uncorr_cnt_q;
`endif

endmodule

// File: tb/tb_ecc_secded_decoder.sv
// Scoreboard bench for ecc_secded_decoder (DATA_W=32); counter checks run when ECC_DEC_ERR_CNT_EN is defined.
module tb_ecc_secded_decoder;

    localparam int DW = 32;
    localparam int PW = 6;
    localparam int CW = 39;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [CW-1:0] cw_i = '0;
    logic          valid_i = 1'b0;
    logic          ready_o;
    logic [DW-1:0] data_o;
    logic          valid_o;
    logic          ready_i = 1'b1;
    logic          err_corr_o;
    logic          err_uncorr_o;
    logic [PW-1:0] syndrome_o;
`ifdef ECC_DEC_ERR_CNT_EN
    logic          cnt_clr_i = 1'b0;
    logic [15:0]   corr_cnt_o;
    logic [15:0]   uncorr_cnt_o;
`endif

    ecc_secded_decoder #(.DATA_W(DW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cw_i         (cw_i),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .data_o       (data_o),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .err_corr_o   (err_corr_o),
        .err_uncorr_o (err_uncorr_o),
        .syndrome_o   (syndrome_o)
`ifdef ECC_DEC_ERR_CNT_EN
        ,
        .cnt_clr_i    (cnt_clr_i),
        .corr_cnt_o   (corr_cnt_o),
        .uncorr_cnt_o (uncorr_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          corr;
        logic          uncorr;
        logic [PW-1:0] syn;
        logic          lat;
        logic [31:0]   cyc;
    } exp_t;

    typedef struct packed {
        logic [CW-1:0] cw;
        logic [DW-1:0] data;
        logic          corr;
        logic          uncorr;
        logic [PW-1:0] syn;
    } vec_t;

    exp_t sb[$];
    exp_t cur;
    int   occ = 0;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    bit   seen_stall = 1'b0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [CW-1:0] enc(input logic [DW-1:0] d);
        logic [CW-1:0] c;
        int j;
        c = '0;
        j = 0;
        for (int pos = 1; pos < CW; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                c[pos] = d[j];
                j++;
            end
        end
        for (int k = 0; k < PW; k++) begin
            logic p;
            p = 1'b0;
            for (int pos = 1; pos < CW; pos++)
                if (((pos >> k) & 1) == 1) p ^= c[pos];
            c[1 << k] = p;
        end
        c[0] = ^c[CW-1:1];
        return c;
    endfunction

    function automatic logic [CW-1:0] flip(input logic [CW-1:0] c, input int k);
        return c ^ (CW'(1) << k);
    endfunction

    // Scoreboard: push on accept, compare the head while valid_o, pop on transfer.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            sb.delete();
            occ = 0;
        end else begin
            chk("ready_o", ready_o, (occ < 2) || ready_i);
            if (occ == 2 && !ready_i) seen_stall = 1'b1;
            if (valid_o) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_out: got data 0x%0h with nothing outstanding (cycle %0d)", data_o, cyc);
                end else begin
                    e = sb[0];
                    chk("data_o", data_o, e.data);
                    chk("err_corr_o", err_corr_o, e.corr);
                    chk("err_uncorr_o", err_uncorr_o, e.uncorr);
                    chk("syndrome_o", syndrome_o, e.syn);
                    if (ready_i) begin
                        void'(sb.pop_front());
                        if (e.lat) chk("latency", 64'(cyc - int'(e.cyc)), 2);
                    end
                end
            end
            if (valid_i && ready_o) begin
                e = cur;
                e.cyc = cyc;
                sb.push_back(e);
            end
            occ = occ + ((valid_i && ready_o) ? 1 : 0) - ((valid_o && ready_i) ? 1 : 0);
        end
    end

    task automatic send(input logic [CW-1:0] c, input logic [DW-1:0] d, input logic corr,
                        input logic uncorr, input logic [PW-1:0] s, input logic lat);
        bit acc;
        int waited;
        cur.data   = d;
        cur.corr   = corr;
        cur.uncorr = uncorr;
        cur.syn    = s;
        cur.lat    = lat;
        cur.cyc    = '0;
        cw_i    = c;
        valid_i = 1'b1;
        waited  = 0;
        do begin
            @(negedge clk);
            acc = ready_o;
            @(posedge clk);
            #1;
            waited++;
        end while (!acc && waited < 100);
        valid_i = 1'b0;
        if (!acc) begin
            n_chk++;
            n_fail++;
            $display("FAIL send_timeout: got no accept in %0d cycles, required accept", waited);
        end
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (occ != 0 && w < 200) begin
            @(posedge clk);
            w++;
        end
        #1;
        chk("drain_outstanding", 64'(occ), 0);
    endtask

    vec_t          vecs[11];
    logic [CW-1:0] e_cw;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got simulation timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        e_cw = enc(32'hDEADBEEF);
        vecs[0]  = '{e_cw,                                  32'hDEADBEEF, 1'b0, 1'b0, 6'd0};
        vecs[1]  = '{flip(e_cw, 3),                         32'hDEADBEEF, 1'b1, 1'b0, 6'd3};
        vecs[2]  = '{flip(e_cw, 0),                         32'hDEADBEEF, 1'b1, 1'b0, 6'd0};
        vecs[3]  = '{flip(flip(e_cw, 5), 9),                32'hDEADBEFD, 1'b0, 1'b1, 6'd12};
        vecs[4]  = '{flip(e_cw, 1),                         32'hDEADBEEF, 1'b1, 1'b0, 6'd1};
        vecs[5]  = '{flip(e_cw, 32),                        32'hDEADBEEF, 1'b1, 1'b0, 6'd32};
        vecs[6]  = '{flip(e_cw, 38),                        32'hDEADBEEF, 1'b1, 1'b0, 6'd38};
        vecs[7]  = '{flip(flip(flip(e_cw, 0), 1), 38),      32'h5EADBEEF, 1'b0, 1'b1, 6'd39};
        vecs[8]  = '{enc(32'h0),                            32'h00000000, 1'b0, 1'b0, 6'd0};
        vecs[9]  = '{flip(enc(32'hFFFFFFFF), 37),           32'hFFFFFFFF, 1'b1, 1'b0, 6'd37};
        vecs[10] = '{flip(flip(enc(32'h0), 0), 3),          32'h00000001, 1'b0, 1'b1, 6'd3};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid_o", valid_o, 0);
        chk("rst_data_o", data_o, 0);
        chk("rst_err_corr_o", err_corr_o, 0);
        chk("rst_err_uncorr_o", err_uncorr_o, 0);
        chk("rst_syndrome_o", syndrome_o, 0);
`ifdef ECC_DEC_ERR_CNT_EN
        chk("rst_corr_cnt_o", corr_cnt_o, 0);
        chk("rst_uncorr_cnt_o", uncorr_cnt_o, 0);
`endif
        rst_n = 1'b1;

        // Clean stream with latency tracking
        for (int i = 0; i < 4; i++) send(e_cw, 32'hDEADBEEF, 1'b0, 1'b0, 6'd0, 1'b1);
        drain();

        for (int i = 0; i < 11; i++)
            send(vecs[i].cw, vecs[i].data, vecs[i].corr, vecs[i].uncorr, vecs[i].syn, 1'b0);
        drain();

        // Back-pressure: ready_i low for cycles 3..6 of a 6-word burst
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    logic [DW-1:0] d;
                    d = 32'h01010101 * (i + 1);
                    send(enc(d), d, 1'b0, 1'b0, 6'd0, 1'b0);
                end
            end
            begin
                repeat (2) @(posedge clk);
                #1 ready_i = 1'b0;
                repeat (4) @(posedge clk);
                #1 ready_i = 1'b1;
            end
        join
        drain();
        chk("stall_seen", seen_stall, 1);

        // Reset with two words in flight
        send(enc(32'hAAAA5555), 32'hAAAA5555, 1'b0, 1'b0, 6'd0, 1'b0);
        send(enc(32'h5555AAAA), 32'h5555AAAA, 1'b0, 1'b0, 6'd0, 1'b0);
        chk("pre_rst_valid_o", valid_o, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid_o", valid_o, 0);
        chk("midrst_data_o", data_o, 0);
        chk("midrst_syndrome_o", syndrome_o, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        send(enc(32'h12345678), 32'h12345678, 1'b0, 1'b0, 6'd0, 1'b1);
        drain();

`ifdef ECC_DEC_ERR_CNT_EN
        for (int i = 0; i < 70000; i++) begin
            int pos;
            pos = 1 + (i % 38);
            send(flip(e_cw, pos), 32'hDEADBEEF, 1'b1, 1'b0, PW'(pos), 1'b0);
        end
        drain();
        chk("corr_cnt_sat", corr_cnt_o, 16'hFFFF);
        chk("uncorr_cnt_zero", uncorr_cnt_o, 0);

        send(flip(e_cw, 3), 32'hDEADBEEF, 1'b1, 1'b0, 6'd3, 1'b0);
        begin
            int w;
            w = 0;
            do begin
                @(negedge clk);
                w++;
            end while (!valid_o && w < 20);
            chk("clr_beat_valid", valid_o, 1);
            cnt_clr_i = 1'b1;
            @(posedge clk);
            #1 cnt_clr_i = 1'b0;
        end
        chk("corr_cnt_clr", corr_cnt_o, 0);
        send(flip(e_cw, 7), 32'hDEADBEEF, 1'b1, 1'b0, 6'd7, 1'b0);
        drain();
        chk("corr_cnt_after_clr", corr_cnt_o, 1);
`endif

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ecc_secded_decoder.md
ECC_SECDED_DECODER -- requirements
Module: ecc_secded_decoder

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning payload data width in bits (range 4..64).
REQ-002 SHALL have derived parameter P = smallest p with 2**p >= DATA_W+p+1 (P=6 for DATA_W=32), N = DATA_W+P, CW_W = N+1.
REQ-003 SHALL have port clk input 1, the single clock; all state on rising edge.
REQ-004 SHALL have port rst_n input 1, asynchronous active-low reset.
REQ-005 SHALL have port cw_i input CW_W, the received codeword: bit 0 is overall parity; bits 1..N are Hamming positions 1..N, with check bits at power-of-two positions and data bits in ascending order at the remaining positions.
REQ-006 SHALL have port valid_i input 1 and ready_o output 1, the input handshake.
REQ-007 SHALL have port data_o output DATA_W, the corrected data, with valid_o output 1 and ready_i input 1 as the output handshake.
REQ-008 SHALL have port err_corr_o output 1, meaning a single error was corrected, qualified by valid_o.
REQ-009 SHALL have port err_uncorr_o output 1, meaning an uncorrectable error, qualified by valid_o.
REQ-010 SHALL have port syndrome_o output P, the raw syndrome, qualified by valid_o.
REQ-011 SHALL have ports cnt_clr_i input 1, corr_cnt_o output 16 and uncorr_cnt_o output 16, present only under ECC_DEC_ERR_CNT_EN.

Function
REQ-012 SHALL be a 2-stage pipeline: S1 registers the codeword, the syndrome S (bit k = XOR of positions with bit k set) and Q (XOR of bits 0..N); S2 registers the corrected outputs.
REQ-013 SHALL have latency exactly 2 cycles from an accepted input (valid_i&ready_o) to valid_o when ready_i stays high.
REQ-014 SHALL sustain 1 word/cycle with no bubbles while ready_i=1.
REQ-015 SHALL advance a stage only when it is empty or its downstream stage advances; ready_o = !s1_valid | s1_advance (combinational stall chain).
REQ-016 SHALL hold data_o, valid_o and flags stable while valid_o=1 and ready_i=0.
REQ-017 SHALL output, for S=0 and Q=0: no error, err_corr=0, err_uncorr=0.
REQ-018 SHALL, for Q=1 and 1<=S<=N, invert position S before data extraction and set err_corr=1.
REQ-019 SHALL, for Q=1 and S=0, treat bit 0 as in error, leave data unchanged and set err_corr=1.
REQ-020 SHALL, for Q=1 and S>N, set err_uncorr=1 and pass data uncorrected.
REQ-021 SHALL, for Q=0 and S!=0 (double error), set err_uncorr=1 and pass data uncorrected.
REQ-022 SHALL never assert err_corr and err_uncorr together.
REQ-023 SHALL, with the counters compiled in, increment corr_cnt/uncorr_cnt once per output beat transferred (valid_o&ready_i) carrying the respective flag, saturating at 0xFFFF.
REQ-024 SHALL give cnt_clr_i priority over a simultaneous increment: the counter reads 0 next cycle and that beat is not counted.

Reset
REQ-025 SHALL, with rst_n low, asynchronously clear both stage valids, so valid_o=0, data_o=0, err_corr_o=0, err_uncorr_o=0, syndrome_o=0 and both counters 0.
REQ-026 SHALL drop any in-flight words when reset asserts mid-stream; after deassertion the first output is the first word accepted after reset.
REQ-027 SHALL drive ready_o=1 in the first cycle after reset deassertion.

Configuration
REQ-028 SHALL use macro ECC_DEC_ERR_CNT_EN: when defined, the cnt_clr_i, corr_cnt_o and uncorr_cnt_o ports and the counter logic exist; when undefined they are absent and decode behaviour and timing are otherwise identical.

Verification (DATA_W=32, CW_W=39, E = correct encoding of 0xDEADBEEF)
REQ-029 SHALL cover clean stream: E on 4 consecutive cycles with ready_i=1 -> data_o=0xDEADBEEF on cycles 2..5, no flags, syndrome_o=0.
REQ-030 SHALL cover single errors: E with bit 3 flipped (data bit 0) -> data_o=0xDEADBEEF, err_corr_o=1, syndrome_o=3; E with bit 0 flipped -> data_o=0xDEADBEEF, err_corr_o=1, syndrome_o=0.
REQ-031 SHALL cover double error: E with bits 5 and 9 flipped -> err_uncorr_o=1, syndrome_o=12, err_corr_o=0, data_o uncorrected.
REQ-032 SHALL cover back-pressure: 6 words sent while ready_i is low for cycles 3..6 -> all 6 words output in order, none lost or duplicated, ready_o low while both stages are full.
REQ-033 SHALL cover counters (macro defined): 70000 single-error beats -> corr_cnt_o=0xFFFF; then cnt_clr_i pulsed together with an error beat -> corr_cnt_o=0.
REQ-034 SHALL cover reset: rst_n asserted with 2 words in flight -> valid_o=0 at once and neither word appears after release.
